// File: rtl/ether_tx_arb.sv
// Frame-level round-robin arbiter sharing the 8-bit MAC TX stream between two
// frame sources, with inter-frame gap, oversize truncation and status counters.
module ether_tx_arb #(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MAX_LEN    = 1514
) (
  input  logic        i_clk125,
  input  logic        i_rst,
  input  logic        i_s0_dval,
  input  logic [7:0]  i_s0_data,
  input  logic        i_s0_sop,
  input  logic        i_s0_eop,
  output logic        o_s0_rdy,
  input  logic        i_s1_dval,
  input  logic [7:0]  i_s1_data,
  input  logic        i_s1_sop,
  input  logic        i_s1_eop,
  output logic        o_s1_rdy,
  output logic        o_tx_dval,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_sop,
  output logic        o_tx_eop,
  output logic        o_tx_err,
  input  logic        i_tx_rdy,
  output logic [1:0]  o_grant,
  output logic [15:0] o_frames0,
  output logic [15:0] o_frames1,
  output logic [7:0]  o_trunc_cnt
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  grant;
  logic        last_served;
  logic [10:0] beat_cnt;
  logic [15:0] gap_cnt;
  logic [15:0] frames0, frames1;
  logic [7:0]  trunc_cnt;

  logic        req0, req1, pick, owner;
  logic        src_dval, src_sop, src_eop;
  logic [7:0]  src_data;
  logic        at_max, beat_acc, frame_done, trunc_hit, drain_done, gap_done;
  state_t      end_state;

  assign req0  = i_s0_dval && i_s0_sop;
  assign req1  = i_s1_dval && i_s1_sop;
  // On a tie the source not served last wins; otherwise whichever requests.
  assign pick  = (req0 && req1) ? ~last_served : req1;
  assign owner = grant[1];

  assign src_dval = owner ? i_s1_dval : i_s0_dval;
  assign src_data = owner ? i_s1_data : i_s0_data;
  assign src_sop  = owner ? i_s1_sop  : i_s0_sop;
  assign src_eop  = owner ? i_s1_eop  : i_s0_eop;

  assign at_max     = (beat_cnt == 11'(MAX_LEN - 1));
  assign beat_acc   = (state == XFER) && src_dval && i_tx_rdy;
  assign frame_done = beat_acc && src_eop;
  assign trunc_hit  = beat_acc && !src_eop && at_max;
  assign drain_done = (state == DRAIN) && src_dval && src_eop;
  assign gap_done   = (32'(gap_cnt) + 32'd1 >= IFG_CYCLES);
  assign end_state  = (IFG_CYCLES == 0) ? IDLE : GAP;

  always_ff @(posedge i_clk125) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (req0 || req1) state_nxt = XFER;
      XFER:  if (frame_done) state_nxt = end_state;
             else if (trunc_hit) state_nxt = DRAIN;
      DRAIN: if (drain_done) state_nxt = end_state;
      GAP:   if (gap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_s0_rdy  = 1'b0;
    o_s1_rdy  = 1'b0;
    o_tx_dval = 1'b0;
    o_tx_data = '0;
    o_tx_sop  = 1'b0;
    o_tx_eop  = 1'b0;
    o_tx_err  = 1'b0;
    unique case (state)
      IDLE: begin
        o_s0_rdy = i_s0_dval && !i_s0_sop;
        o_s1_rdy = i_s1_dval && !i_s1_sop;
      end
      XFER: begin
        o_tx_dval = src_dval;
        o_tx_data = src_data;
        o_tx_sop  = src_sop;
        o_tx_eop  = src_eop || (src_dval && at_max);
        o_tx_err  = src_dval && at_max && !src_eop;
        o_s0_rdy  = !owner && i_tx_rdy;
        o_s1_rdy  = owner && i_tx_rdy;
      end
      DRAIN: begin
        o_s0_rdy = !owner;
        o_s1_rdy = owner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk125) begin
    if (i_rst) begin
      grant       <= '0;
      last_served <= 1'b1;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      frames0     <= '0;
      frames1     <= '0;
      trunc_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: if (req0 || req1) begin
          grant    <= pick ? 2'b10 : 2'b01;
          beat_cnt <= '0;
        end
        XFER: begin
          if (beat_acc) beat_cnt <= beat_cnt + 11'd1;
          if (frame_done) begin
            if (owner) frames1 <= frames1 + 16'd1;
            else       frames0 <= frames0 + 16'd1;
            last_served <= owner;
            grant       <= '0;
            gap_cnt     <= '0;
          end
          if (trunc_hit && trunc_cnt != 8'hFF) trunc_cnt <= trunc_cnt + 8'd1;
        end
        DRAIN: if (drain_done) begin
          last_served <= owner;
          grant       <= '0;
          gap_cnt     <= '0;
        end
        GAP: gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  assign o_grant     = grant;
  assign o_frames0   = frames0;
  assign o_frames1   = frames1;
  assign o_trunc_cnt = trunc_cnt;

endmodule

// File: tb/tb_ether_tx_arb.sv
// Bench for ether_tx_arb: queue-driven sources, per-source expected beat
// streams derived from frame length and MAX_LEN, directed plus random phases.
module tb_ether_tx_arb;
  localparam int unsigned IFG  = 12;
  localparam int unsigned MAXL = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s0_dval, s0_sop, s0_eop, s0_rdy;
  logic s1_dval, s1_sop, s1_eop, s1_rdy;
  logic [7:0] s0_data, s1_data;
  logic tx_dval, tx_sop, tx_eop, tx_err, tx_rdy;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic [15:0] frames0, frames1;
  logic [7:0] trunc;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  int dval_seen = 0;
  logic rdy_rand = 1'b0;

  logic [9:0]  q0[$], q1[$];        // source beats {sop,eop,data}
  logic [10:0] exp0[$], exp1[$];    // expected MAC beats {err,sop,eop,data}
  logic [10:0] cap0[$], cap1[$];
  int          order[$];
  int unsigned sop_cyc[$], eop_cyc[$];
  logic [15:0] fr_exp0 = '0, fr_exp1 = '0;
  logic [7:0]  tr_exp = '0;

  ether_tx_arb #(.IFG_CYCLES(IFG), .MAX_LEN(MAXL)) dut (
    .i_clk125(clk), .i_rst(rst),
    .i_s0_dval(s0_dval), .i_s0_data(s0_data), .i_s0_sop(s0_sop), .i_s0_eop(s0_eop), .o_s0_rdy(s0_rdy),
    .i_s1_dval(s1_dval), .i_s1_data(s1_data), .i_s1_sop(s1_sop), .i_s1_eop(s1_eop), .o_s1_rdy(s1_rdy),
    .o_tx_dval(tx_dval), .o_tx_data(tx_data), .o_tx_sop(tx_sop), .o_tx_eop(tx_eop),
    .o_tx_err(tx_err), .i_tx_rdy(tx_rdy), .o_grant(grant),
    .o_frames0(frames0), .o_frames1(frames1), .o_trunc_cnt(trunc)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : drv0
    logic acc;
    s0_dval = 0; s0_sop = 0; s0_eop = 0; s0_data = '0;
    forever begin
      @(negedge clk); acc = s0_dval && s0_rdy;
      @(posedge clk); #1;
      if (acc && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin s0_dval = 1; {s0_sop, s0_eop, s0_data} = q0[0]; end
      else begin s0_dval = 0; s0_sop = 0; s0_eop = 0; s0_data = '0; end
    end
  end

  initial begin : drv1
    logic acc;
    s1_dval = 0; s1_sop = 0; s1_eop = 0; s1_data = '0;
    forever begin
      @(negedge clk); acc = s1_dval && s1_rdy;
      @(posedge clk); #1;
      if (acc && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin s1_dval = 1; {s1_sop, s1_eop, s1_data} = q1[0]; end
      else begin s1_dval = 0; s1_sop = 0; s1_eop = 0; s1_data = '0; end
    end
  end

  initial begin : mac_rdy
    tx_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (tx_dval) dval_seen++;
      if (tx_dval && tx_rdy) begin
        if (grant == 2'b10) cap1.push_back({tx_err, tx_sop, tx_eop, tx_data});
        else                cap0.push_back({tx_err, tx_sop, tx_eop, tx_data});
        if (tx_sop) begin order.push_back(grant == 2'b10 ? 1 : 0); sop_cyc.push_back(cyc); end
        if (tx_eop) eop_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected output: first min(len,MAXL) bytes; an overlong frame ends with forced eop+err.
  task automatic push_frame(input int n, input int len);
    logic [7:0] d;
    logic sp, ep, fe, fr;
    for (int i = 0; i < len; i++) begin
      d  = 8'($urandom);
      sp = (i == 0);
      ep = (i == len - 1);
      if (n == 0) q0.push_back({sp, ep, d}); else q1.push_back({sp, ep, d});
      if (i < int'(MAXL)) begin
        fr = (i == int'(MAXL) - 1) && !ep;
        fe = ep || fr;
        if (n == 0) exp0.push_back({fr, sp, fe, d}); else exp1.push_back({fr, sp, fe, d});
      end
    end
    if (len <= int'(MAXL)) begin
      if (n == 0) fr_exp0 = fr_exp0 + 16'd1; else fr_exp1 = fr_exp1 + 16'd1;
    end else if (tr_exp != 8'hFF) tr_exp = tr_exp + 8'd1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || grant != 2'b00) && n < 20000) begin
      @(negedge clk); n++;
    end
    check({tag, " timeout"}, 32'(n < 20000), 32'd1);
    repeat (IFG + 4) @(negedge clk);
    #1;
  endtask

  task automatic compare_caps(input string tag);
    check({tag, " s0 beats"}, cap0.size(), exp0.size());
    for (int i = 0; i < cap0.size() && i < exp0.size(); i++) begin
      check($sformatf("%s s0 beat %0d", tag, i), 32'(cap0[i]), 32'(exp0[i]));
      if (cap0[i] !== exp0[i]) break;
    end
    check({tag, " s1 beats"}, cap1.size(), exp1.size());
    for (int i = 0; i < cap1.size() && i < exp1.size(); i++) begin
      check($sformatf("%s s1 beat %0d", tag, i), 32'(cap1[i]), 32'(exp1[i]));
      if (cap1[i] !== exp1[i]) break;
    end
    cap0.delete(); cap1.delete(); exp0.delete(); exp1.delete();
    order.delete(); sop_cyc.delete(); eop_cyc.delete();
  endtask

  task automatic check_counters(input string tag);
    check({tag, " frames0"}, 32'(frames0), 32'(fr_exp0));
    check({tag, " frames1"}, 32'(frames1), 32'(fr_exp1));
    check({tag, " trunc"},   32'(trunc),   32'(tr_exp));
  endtask

  initial begin : main
    int ds;
    // reset state
    repeat (4) @(negedge clk);
    check("rst tx_dval", 32'(tx_dval), 0);
    check("rst tx_sop",  32'(tx_sop), 0);
    check("rst tx_eop",  32'(tx_eop), 0);
    check("rst tx_err",  32'(tx_err), 0);
    check("rst tx_data", 32'(tx_data), 0);
    check("rst grant",   32'(grant), 0);
    check("rst s0_rdy",  32'(s0_rdy), 0);
    check("rst s1_rdy",  32'(s1_rdy), 0);
    check_counters("rst");
    rst = 1'b0;

    // single 60-byte frame from source 0
    push_frame(0, 60);
    wait_idle("t1");
    check("t1 frame count", order.size(), 1);
    compare_caps("t1");
    check_counters("t1");

    // simultaneous requests after reset: strict alternation, exact gap spacing
    rst = 1'b1;
    fr_exp0 = '0; fr_exp1 = '0; tr_exp = '0;
    for (int f = 0; f < 3; f++) begin
      push_frame(0, int'($urandom_range(2, 60)));
      push_frame(1, int'($urandom_range(2, 60)));
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_idle("t2");
    check("t2 frame count", order.size(), 6);
    for (int i = 0; i < order.size(); i++)
      check($sformatf("t2 grant order %0d", i), order[i], i % 2);
    for (int i = 1; i < sop_cyc.size() && i <= eop_cyc.size(); i++)
      check($sformatf("t2 eop-to-sop %0d", i), sop_cyc[i] - eop_cyc[i-1], IFG + 2);
    compare_caps("t2");
    check_counters("t2");

    // stray bytes from source 1 in IDLE are swallowed
    ds = dval_seen;
    for (int i = 0; i < 5; i++) q1.push_back({2'b00, 8'($urandom)});
    wait_idle("t3");
    check("t3 stray queue drained", q1.size(), 0);
    check("t3 no tx_dval", dval_seen, ds);

    // 100-byte frame against MAX_LEN=64: truncate, drain rest
    push_frame(0, 100);
    wait_idle("t4");
    compare_caps("t4");
    check_counters("t4");

    // random MAC backpressure, random sources and lengths
    rdy_rand = 1'b1;
    for (int f = 0; f < 10; f++)
      push_frame(int'($urandom_range(0, 1)), int'($urandom_range(2, 100)));
    wait_idle("t5");
    rdy_rand = 1'b0;
    compare_caps("t5");
    check_counters("t5");

    // reset on beat 20 of a 40-byte frame
    for (int i = 0; i < 40; i++) q0.push_back({i == 0, i == 39, 8'(i + 8'h40)});
    begin
      int n = 0;
      while (cap0.size() < 20 && n < 2000) begin @(negedge clk); #1; n++; end
      check("t6 reach beat 20", 32'(cap0.size()), 20);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    check("t6 tx_dval", 32'(tx_dval), 0);
    check("t6 grant", 32'(grant), 0);
    fr_exp0 = '0; fr_exp1 = '0; tr_exp = '0;
    check_counters("t6 rst");
    rst = 1'b0;
    wait_idle("t6 flush");
    cap0.delete(); cap1.delete(); order.delete(); sop_cyc.delete(); eop_cyc.delete();
    push_frame(0, 30);
    wait_idle("t6");
    compare_caps("t6");
    check_counters("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ether_tx_arb.md
# ether_tx_arb

Frame-level transmit arbiter in front of the Ethernet MAC TX stream. It shares the single 8-bit MAC transmit interface between two frame sources: the collector frame builder (source 0) and an auxiliary frame source such as ARP/heartbeat (source 1). Whole frames are granted round-robin, a programmable inter-frame gap is enforced, and oversize frames are truncated with an error flag. Per-source frame counters are kept for status.

## Interface

Parameters:
- IFG_CYCLES, 12: idle clock cycles inserted after every frame end (0 allowed).
- MAX_LEN, 1514: maximum forwarded beats per frame, including the eop beat (range 2..2047).

Ports:
- i_clk125  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_s0_dval, i_s1_dval  in  1  source N byte valid.
- i_s0_data, i_s1_data  in  8  source N byte.
- i_s0_sop, i_s1_sop  in  1  source N first byte of frame.
- i_s0_eop, i_s1_eop  in  1  source N last byte of frame.
- o_s0_rdy, o_s1_rdy  out  1  source N byte accepted when dval&&rdy.
- o_tx_dval  out  1  byte valid to MAC.
- o_tx_data  out  8  byte to MAC.
- o_tx_sop, o_tx_eop  out  1  frame delimiters to MAC.
- o_tx_err  out  1  asserted with the forced eop beat of a truncated frame.
- i_tx_rdy  in  1  MAC accepts beat when o_tx_dval&&i_tx_rdy.
- o_grant  out  2  one-hot current owner (00 when not in XFER/DRAIN).
- o_frames0, o_frames1  out  16  completed frames per source, wrapping.
- o_trunc_cnt  out  8  truncated frames, saturating at 255.

## Operation

- States: IDLE, XFER, DRAIN, GAP. Registered: state, grant, last-served pointer, 11-bit beat counter, gap counter, status counters.
- Request N = i_sN_dval && i_sN_sop.
- IDLE: if one request, grant it; if both, grant the source not last served; next state XFER, beat counter cleared. Stray bytes (dval with sop=0) are discarded: o_sN_rdy=1 for that source in IDLE, nothing forwarded. Requesting sources see rdy=0 in IDLE.
- XFER: combinational pass-through from granted source: o_tx_dval/data/sop/eop = granted inputs; granted o_sN_rdy = i_tx_rdy; other source rdy=0. On each accepted beat the beat counter increments.
  - Accepted beat with eop: frames counter of owner +1, last-served = owner, go GAP (IDLE if IFG_CYCLES=0).
  - Accepted beat number MAX_LEN (counter == MAX_LEN-1) without source eop: o_tx_eop and o_tx_err forced 1 on that beat, o_trunc_cnt +1 (saturating), frames counter unchanged, go DRAIN.
  - sop seen mid-frame is forwarded unchanged; no check.
- DRAIN: o_tx_dval=0; owner rdy=1; bytes discarded until an accepted source eop beat, then last-served = owner, go GAP.
- GAP: all rdy=0, o_tx_dval=0; counts IFG_CYCLES cycles then IDLE.
- Outputs o_tx_* are 0 in every state except XFER.

## Timing

- Reset: state IDLE, grant 00, last-served = 1 (source 0 wins first tie), counters 0; o_tx_dval/sop/eop/err = 0, o_tx_data = 0, all rdy = 0 except stray-byte discard in IDLE.
- Arbitration latency: request sampled in IDLE at cycle T, first byte presented to MAC at T+1.
- Pass-through latency 0 cycles in XFER; MAC backpressure (i_tx_rdy=0) holds source byte unchanged; source must hold data while dval&&!rdy.
- Frame-to-frame spacing: eop accepted at T, GAP T+1..T+IFG_CYCLES, IDLE at T+IFG_CYCLES+1, next first byte at T+IFG_CYCLES+2.
- Reset mid-frame aborts immediately: next cycle o_tx_dval=0, no eop emitted; MAC-side recovery is MAC's responsibility.
- Counters update on the cycle after the qualifying beat; o_frames wraps 65535->0.

## Test plan

- Single frame, 60 bytes, source 0, i_tx_rdy=1: 60 beats out, sop on beat 1, eop on beat 60, o_frames0=1, next grant no earlier than 13 cycles after eop (IFG_CYCLES=12).
- Both sources request simultaneously after reset, 3 frames each: grant order 0,1,0,1,0,1; o_frames0=o_frames1=3.
- Random i_tx_rdy (50%) on a 100-byte frame: output byte sequence equals input exactly, no duplicates/drops.
- MAX_LEN=64, source sends 100-byte frame: 64 beats out, beat 64 has eop=1, err=1; remaining 36 bytes drained; o_trunc_cnt=1, o_frames0=0.
- Stray bytes from source 1 (dval, no sop) in IDLE: accepted and discarded, o_tx_dval stays 0.
- i_rst asserted on beat 20 of a frame: next cycle o_tx_dval=0, o_grant=00, all counters 0; new frame after reset forwards normally.
